// File: rtl/button_debouncer.sv
// button_debouncer
// Takes a raw, asynchronous, bouncing button line, synchronizes it to clk
// and accepts a level change only after it has been seen for STABLE_CYCLES
// consecutive synchronized samples. Produces a clean level, one-cycle
// press/release pulses, a wrapping press counter and a saturating counter
// of aborted qualification attempts.
//
// There is no valid/ready interface on this block: btn_in is a free-running
// level and all outputs are registered levels/pulses, valid every cycle.
module button_debouncer #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [7:0] press_count,
    output logic [7:0] bounce_count,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Qualification ends when the counter already holds STABLE_CYCLES-1 and
    // one more matching sample arrives (the entering sample counts as 1).
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    logic       s1_q;
    logic       sync_q;
    state_t     state_q,        state_d;
    logic [7:0] cnt_q,          cnt_d;
    logic       level_q,        level_d;
    logic       press_q,        press_d;
    logic       release_q,      release_d;
    logic [7:0] press_cnt_q,    press_cnt_d;
    logic [7:0] bounce_cnt_q,   bounce_cnt_d;
    logic [7:0] bounce_cnt_inc;

    // Aborts stop counting at 255 instead of wrapping.
    assign bounce_cnt_inc = (bounce_cnt_q == 8'hFF) ? bounce_cnt_q : bounce_cnt_q + 8'd1;

    // Two-flop synchronizer; only sync_q is allowed to feed the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            s1_q   <= btn_in;
            sync_q <= s1_q;
        end
    end

    // Next-state logic: qualify each level change, count aborts and presses.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        level_d      = level_q;
        press_d      = 1'b0;
        release_d    = 1'b0;
        press_cnt_d  = press_cnt_q;
        bounce_cnt_d = bounce_cnt_q;
        case (state_q)
            IDLE: begin
                if (sync_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = 8'd1;
                end
            end
            PRESS_WAIT: begin
                if (!sync_q) begin
                    state_d      = IDLE;
                    cnt_d        = 8'd0;
                    bounce_cnt_d = bounce_cnt_inc;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = PRESSED;
                    cnt_d       = 8'd0;
                    level_d     = 1'b1;
                    press_d     = 1'b1;
                    press_cnt_d = press_cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            PRESSED: begin
                if (!sync_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = 8'd1;
                end
            end
            RELEASE_WAIT: begin
                if (sync_q) begin
                    state_d      = PRESSED;
                    cnt_d        = 8'd0;
                    bounce_cnt_d = bounce_cnt_inc;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = 8'd0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Single state register for the FSM and all of its registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            level_q      <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            press_cnt_q  <= 8'd0;
            bounce_cnt_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            press_q      <= press_d;
            release_q    <= release_d;
            press_cnt_q  <= press_cnt_d;
            bounce_cnt_q <= bounce_cnt_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign press_count   = press_cnt_q;
    assign bounce_count  = bounce_cnt_q;
    assign dbg_state     = state_q;

endmodule
